// File: rtl/dcpu_prefetch_if.sv
// CPU fetch port and system bus signals of the dcpu instruction prefetch queue.
// slave = the prefetch block's view, master = the CPU/bus environment's view.
interface dcpu_prefetch_if;
    logic        i_cpu_stb;
    logic [31:0] i_cpu_addr;
    logic        o_cpu_ack;
    logic [15:0] o_cpu_dat;
    logic        o_cyc;
    logic [1:0]  o_stb;
    logic [31:0] o_addr;
    logic        o_we;
    logic        i_ack;
    logic [15:0] i_dat;

    modport slave (
        input  i_cpu_stb, i_cpu_addr, i_ack, i_dat,
        output o_cpu_ack, o_cpu_dat, o_cyc, o_stb, o_addr, o_we
    );

    modport master (
        output i_cpu_stb, i_cpu_addr, i_ack, i_dat,
        input  o_cpu_ack, o_cpu_dat, o_cyc, o_stb, o_addr, o_we
    );
endinterface

// File: rtl/dcpu_prefetch.sv
// Instruction prefetch queue: serves sequential 16-bit fetches from a FIFO and fetches ahead.
// Optional hit/miss counters are enabled with the DCPU_PREFETCH_CNT_EN macro.
//
// state     | meaning
// B_IDLE    | no bus cycle; issues at f_addr (or the missed address) when allowed
// B_REQ     | bus cycle active at o_addr; response pushed or bypassed to the CPU
// B_DISCARD | bus cycle of a flushed stream; response dropped
module dcpu_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    dcpu_prefetch_if.slave  bus_if
`ifdef DCPU_PREFETCH_CNT_EN
    ,
    output logic [15:0]     o_hits,
    output logic [15:0]     o_misses
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        B_IDLE    = 2'd0,
        B_REQ     = 2'd1,
        B_DISCARD = 2'd2
    } bstate_e;

    bstate_e        b_q, b_d;
    logic [31:0]    q_addr_q, q_addr_d;
    logic [31:0]    f_addr_q, f_addr_d;
    logic [31:0]    bus_addr_q, bus_addr_d;
    logic           sv_q, sv_d;
    logic           pend_q, pend_d;
    logic           ack_q, ack_d;
    logic [15:0]    dat_q, dat_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]    cnt_q, cnt_d;
    logic [15:0]    mem_q [DEPTH];

    logic           push;
    logic           pop;
    logic           flush;
    logic           new_req;
    logic           hit;
    logic           bus_match;
    logic [31:0]    req_addr;

    assign req_addr  = bus_if.i_cpu_addr & ~32'd1;
    // pend_q covers a request already accepted and waiting for its bypassed word
    assign new_req   = bus_if.i_cpu_stb & ~ack_q & ~pend_q;
    assign hit       = sv_q & (cnt_q != '0) & (req_addr == q_addr_q);
    assign bus_match = (b_q == B_REQ) & (bus_addr_q == req_addr);

    always_comb begin
        b_d        = b_q;
        q_addr_d   = q_addr_q;
        f_addr_d   = f_addr_q;
        bus_addr_d = bus_addr_q;
        sv_d       = sv_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        dat_d      = dat_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        if (b_q == B_REQ && bus_if.i_ack) begin
            b_d      = B_IDLE;
            f_addr_d = f_addr_q + 32'd2;
            if (pend_q) begin
                ack_d    = 1'b1;
                dat_d    = bus_if.i_dat;
                pend_d   = 1'b0;
                q_addr_d = q_addr_q + 32'd2;
            end else begin
                push = 1'b1;
            end
        end else if (b_q == B_DISCARD && bus_if.i_ack) begin
            b_d = B_IDLE;
        end

        if (new_req && hit) begin
            pop      = 1'b1;
            ack_d    = 1'b1;
            dat_d    = mem_q[rd_ptr_q];
            q_addr_d = q_addr_q + 32'd2;
        end

        if (new_req && !hit) begin
            // Restart the stream at the requested word; a matching cycle in flight is reused.
            flush = 1'b1;
            push  = 1'b0;
            sv_d  = 1'b1;
            if (bus_match) begin
                if (bus_if.i_ack) begin
                    ack_d    = 1'b1;
                    dat_d    = bus_if.i_dat;
                    q_addr_d = req_addr + 32'd2;
                    f_addr_d = req_addr + 32'd2;
                end else begin
                    pend_d   = 1'b1;
                    q_addr_d = req_addr;
                    f_addr_d = req_addr;
                end
            end else begin
                pend_d   = 1'b1;
                q_addr_d = req_addr;
                f_addr_d = req_addr;
                case (b_q)
                    B_IDLE: begin
                        b_d        = B_REQ;
                        bus_addr_d = req_addr;
                    end
                    B_REQ:   b_d = bus_if.i_ack ? B_IDLE : B_DISCARD;
                    default: ;
                endcase
            end
        end else if (b_q == B_IDLE && sv_q && cnt_q < FULL) begin
            b_d        = B_REQ;
            bus_addr_d = f_addr_q;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            b_q        <= B_IDLE;
            q_addr_q   <= '0;
            f_addr_q   <= '0;
            bus_addr_q <= '0;
            sv_q       <= 1'b0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            b_q        <= b_d;
            q_addr_q   <= q_addr_d;
            f_addr_q   <= f_addr_d;
            bus_addr_q <= bus_addr_d;
            sv_q       <= sv_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_if.i_dat;
    end

    assign bus_if.o_cpu_ack = ack_q;
    assign bus_if.o_cpu_dat = dat_q;
    assign bus_if.o_cyc     = (b_q != B_IDLE);
    assign bus_if.o_stb     = (b_q != B_IDLE) ? 2'b11 : 2'b00;
    assign bus_if.o_addr    = bus_addr_q;
    assign bus_if.o_we      = 1'b0;

`ifdef DCPU_PREFETCH_CNT_EN
    logic        ifl_hit;
    logic [15:0] hits_q;
    logic [15:0] misses_q;

    // A request waiting on a matching cycle with an empty queue still counts as a hit.
    assign ifl_hit = sv_q & (cnt_q == '0) & bus_match;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (new_req) begin
            if (hit || ifl_hit) begin
                if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
            end else begin
                if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
            end
        end
    end

    assign o_hits   = hits_q;
    assign o_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcpu_prefetch.sv
// Bench for dcpu_prefetch: vector table of fetches plus hand-written jump, wrap and reset sequences.
// Delivered words are checked against a scoreboard queue filled when each fetch is driven.
module tb_dcpu_prefetch;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] exp_q [$];
    logic [31:0] bus_log [$];
    int          wait_states = 2;
    bit          bus_en = 1;
    int          ws_cnt = 0;
    logic        prev_cyc = 1'b0;

    dcpu_prefetch_if bif ();

`ifdef DCPU_PREFETCH_CNT_EN
    logic [15:0] hits;
    logic [15:0] misses;
    dcpu_prefetch #(.DEPTH(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus_if(bif),
        .o_hits(hits), .o_misses(misses)
    );
`else
    dcpu_prefetch #(.DEPTH(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus_if(bif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return (a[15:0] ^ a[31:16]) + 16'h1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Bus slave: acks after wait_states cycles with the model memory word.
    initial begin
        bif.i_ack = 1'b0;
        bif.i_dat = '0;
        forever begin
            @(posedge clk); #1;
            if (bus_en) begin
                bif.i_ack = 1'b0;
                if (bif.o_cyc) begin
                    if (ws_cnt >= wait_states) begin
                        bif.i_ack = 1'b1;
                        bif.i_dat = mem_word(bif.o_addr);
                        ws_cnt = 0;
                    end else begin
                        ws_cnt++;
                    end
                end else begin
                    ws_cnt = 0;
                end
            end
        end
    end

    // Scoreboard pop on every CPU ack; bus cycle start log.
    always @(negedge clk) begin
        if (bif.o_cpu_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%h required=none", bif.o_cpu_dat);
            end else begin
                chk("cpu_dat", {16'h0, bif.o_cpu_dat}, {16'h0, exp_q.pop_front()});
            end
        end
        if (bif.o_cyc && !prev_cyc) begin
            bus_log.push_back(bif.o_addr);
            chk("bus_stb", {30'h0, bif.o_stb}, 32'h3);
            chk("bus_we", {31'h0, bif.o_we}, 32'h0);
        end
        prev_cyc = bif.o_cyc;
    end

    task automatic fetch(input logic [31:0] a, input int exp_lat, input string nm);
        int lat;
        bit got;
        @(posedge clk); #1;
        exp_q.push_back(mem_word(a));
        bif.i_cpu_stb  = 1'b1;
        bif.i_cpu_addr = a;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (bif.o_cpu_ack) got = 1'b1;
        end
        bif.i_cpu_stb = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_ack required=ack addr=%h", nm, a);
            void'(exp_q.pop_back());
        end else if (exp_lat > 0) begin
            chk({nm, "_lat"}, lat, exp_lat);
        end
    endtask

    task automatic wait_cyc_rise(input string nm, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (bif.o_cyc && n < 100) begin
            @(posedge clk); #1; n++;
        end
        while (!bif.o_cyc && n < 100) begin
            @(posedge clk); #1; n++;
        end
        ok = bif.o_cyc;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_cycle required=cycle", nm);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          pre_idle;
    } vec_t;

    vec_t tbl [5];

    initial begin
        bit ok;
        logic [31:0] pend_addr;

        tbl[0] = '{32'h0000_0000, 4, 0};
        tbl[1] = '{32'h0000_0002, 1, 24};
        tbl[2] = '{32'h0000_0004, 1, 0};
        tbl[3] = '{32'h0000_0006, 1, 0};
        tbl[4] = '{32'h0000_0008, 1, 0};

        rst_n          = 1'b0;
        bif.i_cpu_stb  = 1'b0;
        bif.i_cpu_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {31'h0, bif.o_cyc}, 32'h0);
        chk("rst_ack", {31'h0, bif.o_cpu_ack}, 32'h0);
        chk("rst_dat", {16'h0, bif.o_cpu_dat}, 32'h0);
        chk("rst_addr", bif.o_addr, 32'h0);
        chk("rst_stb", {30'h0, bif.o_stb}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_issue_before_req", bus_log.size(), 0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pre_idle > 0) begin
                repeat (tbl[i].pre_idle) @(posedge clk);
                #1;
                chk("full_bus_idle", {31'h0, bif.o_cyc}, 32'h0);
                chk("prefetch_count", bus_log.size(), 5);
                for (int k = 0; k < bus_log.size(); k++)
                    chk("prefetch_addr", bus_log[k], tbl[0].addr + 32'(2 * k));
            end
            fetch(tbl[i].addr, tbl[i].lat, "seq");
        end

`ifdef DCPU_PREFETCH_CNT_EN
        chk("cnt_misses", {16'h0, misses}, 32'd1);
        chk("cnt_hits", {16'h0, hits}, 32'd4);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("dat_hold", {16'h0, bif.o_cpu_dat}, {16'h0, mem_word(32'h8)});

        // Jump while a prefetch cycle is outstanding: its data must be dropped.
        wait_cyc_rise("jump_wait", ok);
        pend_addr = bif.o_addr;
        bus_log.delete();
        fetch(32'h0000_0100, 0, "jump");
        chk("jump_log_size", bus_log.size(), 2);
        if (bus_log.size() >= 2) begin
            chk("jump_pending", bus_log[0], pend_addr);
            chk("jump_new_addr", bus_log[1], 32'h0000_0100);
        end

        // Address wrap of the prefetch stream.
        fetch(32'hFFFF_FFFE, 0, "wrap");
        wait_cyc_rise("wrap_wait", ok);
        chk("wrap_addr", bif.o_addr, 32'h0000_0000);
        fetch(32'h0000_0000, 0, "wrap_next");

        // Reset in the middle of a bus cycle, then a late bus ack.
        wait_cyc_rise("rst_wait", ok);
        bus_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'h0, bif.o_cyc}, 32'h0);
        chk("midrst_addr", bif.o_addr, 32'h0);
        chk("midrst_ack", {31'h0, bif.o_cpu_ack}, 32'h0);
        bif.i_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.i_ack = 1'b1;
        bif.i_dat = 16'hDEAD;
        @(posedge clk); #1;
        bif.i_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_cyc", {31'h0, bif.o_cyc}, 32'h0);
        chk("late_ack_dat", {16'h0, bif.o_cpu_dat}, 32'h0);
        bus_en = 1'b1;
        fetch(32'h0000_0200, 4, "post_rst");

        // Zero wait states: miss from an idle bus, then a queue hit.
        repeat (30) @(posedge clk);
        wait_states = 0;
        fetch(32'h0000_0300, 2, "ws0_miss");
        repeat (10) @(posedge clk);
        fetch(32'h0000_0302, 1, "ws0_hit");

        repeat (3) @(posedge clk);
        #1;
        chk("final_hold", {16'h0, bif.o_cpu_dat}, {16'h0, mem_word(32'h302)});
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
